pwm_reg_arbiter: RTL and testbench
==================================

// Module: pwm_reg_arbiter
// PURPOSE
//  Owns the PWM configuration register bank (addr 0..4: out_en[7:0], out_en[15:8], pwm_en[7:0],
//  pwm_en[15:8], duty) and arbitrates write access to it between two requesters.
//  Port A: SPI command decoder. Port B: on-chip sequencer (e.g. duty-cycle fader).
//  Round-robin arbitration, valid/ready handshake, address range check, per-port done/err pulses.
//  Register outputs drive the PWM/output-enable datapath directly.
// PARAMETERS
//  NUM_REGS  5  number of implemented registers; valid addresses are 0..NUM_REGS-1
//  ADDR_W    7  write address width
//  DATA_W    8  register/data width
// PORTS
//  clk             in   1              system clock; all logic on posedge
//  rst             in   1              synchronous reset, active-high
//  a_valid         in   1              port A write request
//  a_addr          in   ADDR_W         port A register address
//  a_data          in   DATA_W         port A write data
//  a_ready         out  1              port A grant; registered, 1-cycle pulse
//  a_done          out  1              port A write committed; 1-cycle pulse
//  a_err           out  1              port A address out of range, write dropped; 1-cycle pulse
//  b_valid/b_addr/b_data/b_ready/b_done/b_err   same as port A, for port B
//  en_reg_out_7_0  out  DATA_W         register 0
//  en_reg_out_15_8 out  DATA_W         register 1
//  en_reg_pwm_7_0  out  DATA_W         register 2
//  en_reg_pwm_15_8 out  DATA_W         register 3
//  pwm_duty_cycle  out  DATA_W         register 4
// BEHAVIOUR
//  Reset: all 5 registers = 0; FSM = IDLE; priority pointer = A; all ready/done/err = 0.
//   Reset mid-transfer aborts the transfer: no register write, no done/err pulse.
//  FSM states: IDLE -> GRANT -> COMMIT -> IDLE.
//   IDLE:   neither valid -> stay. One valid -> grant that port. Both valid -> grant the port
//           the pointer selects. Latch grant id; go GRANT. Assert winner's ready next cycle.
//   GRANT:  winner's ready = 1 for exactly this cycle. Transfer = valid && ready.
//           On transfer, capture addr/data; go COMMIT.
//           If winner's valid = 0 (protocol violation): abort to IDLE, no write, pointer unchanged.
//   COMMIT: addr < NUM_REGS: write data to that register, pulse winner's done.
//           Otherwise: no register change, pulse winner's err.
//           Set pointer to the non-winner; go IDLE.
//  Latency: valid sampled in IDLE at cycle N -> ready at N+1 -> done/err and register
//   update at N+2 edge, i.e. new value visible on outputs from cycle N+3.
//   Max throughput is one write per 3 cycles.
//  Requesters hold valid/addr/data stable from assertion until the cycle ready = 1.
//   Changes to addr/data before that point are undefined.
//  Only the addressed register changes; all other registers retain their values.
//   No clear-on-write of other registers.
//  ready, done and err are never asserted for both ports in the same cycle.
//   At most one of done/err pulses per transfer.
//  Fairness: under continuous requests on both ports, grants alternate A, B, A, B, ...
//   No port waits for more than one foreign transfer.
//  Address compare uses the full ADDR_W bits (e.g. addr 0x44 is an error, not aliased to 4).
//   Data is written verbatim; no width conversion.
// TESTING
//  1. Reset, then A writes addr 4 data 0x80 -> a_ready at N+1; a_done and duty = 0x80 at N+3;
//     regs 0-3 stay 0.
//  2. A and B valid in the same cycle (A: addr0=0xF0, B: addr2=0x0F) -> A granted first, then B;
//     final out_7_0 = 0xF0, pwm_7_0 = 0x0F.
//  3. Both ports hold valid for 6 transfers -> grant order A,B,A,B,A,B;
//     no ready overlap between ports.
//  4. B writes addr 5 data 0xAA -> b_err pulses once, no b_done, all registers unchanged.
//  5. rst asserted in the GRANT cycle of an A write to addr 1 -> en_reg_out_15_8 stays 0,
//     no done/err, FSM IDLE.
//  6. A drops valid in GRANT -> no write, no pulses; a following B request is granted
//     from IDLE normally.

Source files
------------

// File: rtl/pwm_reg_arbiter.sv
// PWM configuration register bank with round-robin arbitrated write access from two requesters.
// Registered ready/done/err; IDLE -> GRANT -> COMMIT gives one write per three cycles.
module pwm_reg_arbiter #(
  parameter int NUM_REGS = 5,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  output logic              a_done,
  output logic              a_err,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              b_done,
  output logic              b_err,
  output logic [DATA_W-1:0] en_reg_out_7_0,
  output logic [DATA_W-1:0] en_reg_out_15_8,
  output logic [DATA_W-1:0] en_reg_pwm_7_0,
  output logic [DATA_W-1:0] en_reg_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle
);

  typedef enum logic [1:0] {IDLE, GRANT, COMMIT} state_t;

  state_t              state_q, state_d;
  logic                gnt_q, gnt_d;   // 0 = port A, 1 = port B
  logic                ptr_q, ptr_d;   // port favoured on a tie
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic                a_ready_q, a_ready_d, b_ready_q, b_ready_d;
  logic                a_done_q, a_done_d, b_done_q, b_done_d;
  logic                a_err_q, a_err_d, b_err_q, b_err_d;
  logic                win_valid;
  logic                in_range;
  logic                wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      ptr_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      a_ready_q <= 1'b0;
      b_ready_q <= 1'b0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      a_err_q   <= 1'b0;
      b_err_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      a_ready_q <= a_ready_d;
      b_ready_q <= b_ready_d;
      a_done_q  <= a_done_d;
      b_done_q  <= b_done_d;
      a_err_q   <= a_err_d;
      b_err_q   <= b_err_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign win_valid = gnt_q ? b_valid : a_valid;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (a_valid || b_valid) begin
          gnt_d   = (a_valid && b_valid) ? ptr_q : b_valid;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A winner that withdrew its request loses the slot without moving the pointer.
        if (win_valid) begin
          addr_d  = gnt_q ? b_addr : a_addr;
          data_d  = gnt_q ? b_data : a_data;
          state_d = COMMIT;
        end else begin
          state_d = IDLE;
        end
      end
      COMMIT: begin
        ptr_d   = ~gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Full-width compare so out-of-range addresses never alias onto a real register.
  assign in_range = ({1'b0, addr_q} < (ADDR_W+1)'(NUM_REGS));
  assign wr_en    = (state_q == COMMIT) && in_range;

  always_comb begin
    a_ready_d = 1'b0;
    b_ready_d = 1'b0;
    a_done_d  = 1'b0;
    b_done_d  = 1'b0;
    a_err_d   = 1'b0;
    b_err_d   = 1'b0;
    if (state_q == IDLE && state_d == GRANT) begin
      a_ready_d = ~gnt_d;
      b_ready_d = gnt_d;
    end
    if (state_q == COMMIT) begin
      a_done_d = ~gnt_q & in_range;
      b_done_d = gnt_q & in_range;
      a_err_d  = ~gnt_q & ~in_range;
      b_err_d  = gnt_q & ~in_range;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && addr_q == ADDR_W'(i)) regs_d[i] = data_q;
    end
  end

  assign a_ready         = a_ready_q;
  assign b_ready         = b_ready_q;
  assign a_done          = a_done_q;
  assign b_done          = b_done_q;
  assign a_err           = a_err_q;
  assign b_err           = b_err_q;
  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];

endmodule

// File: tb/tb_pwm_reg_arbiter.sv
// Directed bench for pwm_reg_arbiter: a vector table of single-port writes plus
// hand sequences for ties, fairness, reset mid-transfer and withdrawn requests.
module tb_pwm_reg_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic [6:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_data = '0, b_data = '0;
  logic       a_ready, a_done, a_err, b_ready, b_done, b_err;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_reg_arbiter #(.NUM_REGS(5), .ADDR_W(7), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
    .a_ready(a_ready), .a_done(a_done), .a_err(a_err),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data),
    .b_ready(b_ready), .b_done(b_done), .b_err(b_err),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle)
  );

  typedef struct {
    bit         port;      // 0 = A, 1 = B
    logic [6:0] addr;
    logic [7:0] data;
    bit         exp_err;
    logic [39:0] exp_regs; // {reg4, reg3, reg2, reg1, reg0}
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] regs_now();
    return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One complete write from a single port, checked cycle by cycle.
  task automatic write_txn(input bit port, input logic [6:0] addr, input logic [7:0] data,
                           input bit exp_err, input logic [39:0] exp_regs, input string tag);
    if (port) begin b_valid = 1'b1; b_addr = addr; b_data = data; end
    else      begin a_valid = 1'b1; a_addr = addr; a_data = data; end
    tick();
    chk({tag, "_ready"}, {a_ready, b_ready}, port ? 2'b01 : 2'b10);
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    chk({tag, "_ready_pulse"}, {a_ready, b_ready}, 2'b00);
    tick();
    chk({tag, "_done_err"}, {a_done, a_err, b_done, b_err},
        port ? {2'b00, !exp_err, exp_err} : {!exp_err, exp_err, 2'b00});
    chk({tag, "_regs"}, regs_now(), exp_regs);
    tick();
    chk({tag, "_pulse_end"}, {a_done, a_err, b_done, b_err}, 4'b0000);
  endtask

  initial begin
    int grants;
    int budget;
    int exp_port;

    vecs[0] = '{0, 7'h04, 8'h80, 0, 40'h80_00_00_00_00};
    vecs[1] = '{1, 7'h05, 8'hAA, 1, 40'h80_00_00_00_00};
    vecs[2] = '{0, 7'h44, 8'h55, 1, 40'h80_00_00_00_00};
    vecs[3] = '{1, 7'h01, 8'h3C, 0, 40'h80_00_00_3C_00};
    vecs[4] = '{0, 7'h03, 8'hA5, 0, 40'h80_A5_00_3C_00};
    vecs[5] = '{1, 7'h04, 8'h11, 0, 40'h11_A5_00_3C_00};
    vecs[6] = '{0, 7'h7F, 8'hFF, 1, 40'h11_A5_00_3C_00};
    vecs[7] = '{1, 7'h00, 8'h01, 0, 40'h11_A5_00_3C_01};
    vecs[8] = '{0, 7'h02, 8'hC3, 0, 40'h11_A5_C3_3C_01};

    do_reset();
    chk("reset_regs", regs_now(), 40'h0);
    chk("reset_hs", {a_ready, a_done, a_err, b_ready, b_done, b_err}, 6'b0);

    for (int i = 0; i < 9; i++)
      write_txn(vecs[i].port, vecs[i].addr, vecs[i].data, vecs[i].exp_err,
                vecs[i].exp_regs, $sformatf("vec%0d", i));

    // Simultaneous requests after reset: A wins, B follows.
    do_reset();
    a_valid = 1'b1; a_addr = 7'h00; a_data = 8'hF0;
    b_valid = 1'b1; b_addr = 7'h02; b_data = 8'h0F;
    tick();
    chk("tie_first_ready", {a_ready, b_ready}, 2'b10);
    tick();
    a_valid = 1'b0;
    tick();
    chk("tie_a_done", {a_done, b_done, b_ready}, 3'b100);
    tick();
    chk("tie_second_ready", {a_ready, b_ready}, 2'b01);
    tick();
    b_valid = 1'b0;
    tick();
    chk("tie_b_done", {a_done, b_done}, 2'b01);
    chk("tie_regs", regs_now(), 40'h00_00_0F_00_F0);

    // Continuous requests on both ports: grants must alternate starting with A.
    tick();
    a_valid = 1'b1; a_addr = 7'h00; a_data = 8'h11;
    b_valid = 1'b1; b_addr = 7'h01; b_data = 8'h22;
    grants = 0;
    budget = 0;
    exp_port = 0;
    while (grants < 6 && budget < 60) begin
      tick();
      budget++;
      chk("fair_no_overlap", {a_ready & b_ready, a_done & b_done, a_err & b_err}, 3'b000);
      if (a_ready || b_ready) begin
        chk($sformatf("fair_grant%0d", grants), {31'b0, b_ready}, exp_port);
        exp_port = 1 - exp_port;
        grants++;
      end
    end
    chk("fair_grant_count", grants, 6);
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
    chk("fair_regs", regs_now(), 40'h00_00_0F_22_11);
    tick();

    // Reset asserted during the GRANT cycle aborts the write.
    do_reset();
    a_valid = 1'b1; a_addr = 7'h01; a_data = 8'h77;
    tick();
    chk("rst_mid_ready", a_ready, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_mid_quiet", {a_ready, a_done, a_err, b_ready, b_done, b_err}, 6'b0);
      chk("rst_mid_regs", regs_now(), 40'h0);
      tick();
    end
    write_txn(0, 7'h01, 8'h42, 0, 40'h00_00_00_42_00, "rst_after");

    // Winner withdraws valid in GRANT: nothing is written, B then proceeds normally.
    a_valid = 1'b1; a_addr = 7'h02; a_data = 8'h99;
    tick();
    chk("drop_ready", {a_ready, b_ready}, 2'b10);
    a_valid = 1'b0;
    tick();
    chk("drop_no_ready", {a_ready, b_ready}, 2'b00);
    tick();
    chk("drop_no_pulse", {a_done, a_err, b_done, b_err}, 4'b0000);
    chk("drop_regs", regs_now(), 40'h00_00_00_42_00);
    write_txn(1, 7'h03, 8'h5A, 0, 40'h00_5A_00_42_00, "drop_then_b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
